// File: rtl/life_frame_capture_if.sv
// Cell stream interface carrying the Game-of-Life engine's serial output.
//   in_valid : a cell bit and its index are present this cycle
//   in_idx   : row-major cell index (row*COLS + col)
//   in_bit   : cell state, 1 = alive
// master = the engine driving the stream, slave = the frame capture block.
interface life_frame_capture_if #(
    parameter int IDX_W = 6
);
    logic             in_valid;
    logic [IDX_W-1:0] in_idx;
    logic             in_bit;

    modport master (output in_valid, output in_idx, output in_bit);
    modport slave  (input  in_valid, input  in_idx, input  in_bit);
endinterface

// File: rtl/life_frame_capture.sv
// Deserialises the Game-of-Life cell stream into a frame buffer, commits each
// completed generation atomically, derives population / generation / pattern
// flags, and exposes the committed frame one row at a time.
// Ports:
//   clk, rst_n   : clock (rising edge), asynchronous active-low reset
//   clear        : synchronous soft clear (everything except the row_data path)
//   cell_if      : slave side of the cell stream (in_valid, in_idx, in_bit)
//   row_sel      : row of the committed frame to read
//   row_data     : registered committed row, bit c = column c
//   frame_valid  : one-cycle pulse when a new frame commits
//   population   : live cells in the committed frame
//   generation   : frames committed since reset/clear (saturating)
//   still_life   : committed frame equals the previous one
//   osc2         : committed frame equals the one two commits back, not the previous
//   extinct      : committed frame is empty
//   seq_err      : sticky out-of-order index flag
module life_frame_capture #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int GEN_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clear,
    life_frame_capture_if.slave           cell_if,
    input  logic [$clog2(ROWS)-1:0]       row_sel,
    output logic [COLS-1:0]               row_data,
    output logic                          frame_valid,
    output logic [$clog2(ROWS*COLS):0]    population,
    output logic [GEN_W-1:0]              generation,
    output logic                          still_life,
    output logic                          osc2,
    output logic                          extinct,
    output logic                          seq_err
);
    localparam int N     = ROWS * COLS;
    localparam int IDX_W = $clog2(N);
    localparam int POP_W = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [N-1:0]     cap_q, cap_d, cur_q, cur_d;
    logic [N-1:0]     prev1_q, prev1_d, prev2_q, prev2_d;
    logic [POP_W-1:0] run_cnt_q, run_cnt_d, population_q, population_d;
    logic [IDX_W-1:0] exp_q, exp_d;
    logic             have_prev_q, have_prev_d, have_prev2_q, have_prev2_d;
    logic             frame_valid_q, frame_valid_d;
    logic [GEN_W-1:0] generation_q, generation_d;
    logic             still_life_q, still_life_d, osc2_q, osc2_d;
    logic             extinct_q, extinct_d, seq_err_q, seq_err_d;
    logic [COLS-1:0]  row_data_q, row_data_d;

    logic [N-1:0]     new_frame;
    logic [POP_W-1:0] new_pop;
    logic             idx_match;

    function automatic logic [GEN_W-1:0] sat_inc(input logic [GEN_W-1:0] v);
        return (v == {GEN_W{1'b1}}) ? v : v + GEN_W'(1);
    endfunction

    always_comb begin
        cap_d         = cap_q;
        cur_d         = cur_q;
        prev1_d       = prev1_q;
        prev2_d       = prev2_q;
        run_cnt_d     = run_cnt_q;
        exp_d         = exp_q;
        have_prev_d   = have_prev_q;
        have_prev2_d  = have_prev2_q;
        frame_valid_d = 1'b0;
        population_d  = population_q;
        generation_d  = generation_q;
        still_life_d  = still_life_q;
        osc2_d        = osc2_q;
        extinct_d     = extinct_q;
        seq_err_d     = seq_err_q;

        // Frame as it will look if this cycle carries the last cell.
        new_frame          = cap_q;
        new_frame[N-1]     = cell_if.in_bit;
        new_pop            = run_cnt_q + POP_W'(cell_if.in_bit);
        idx_match          = (cell_if.in_idx == exp_q);

        // Readout always tracks cur, even across a soft clear.
        row_data_d = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (int'(row_sel) == r) row_data_d = cur_q[r*COLS +: COLS];
        end

        if (clear) begin
            cap_d        = '0;
            cur_d        = '0;
            prev1_d      = '0;
            prev2_d      = '0;
            run_cnt_d    = '0;
            exp_d        = '0;
            have_prev_d  = 1'b0;
            have_prev2_d = 1'b0;
            population_d = '0;
            generation_d = '0;
            still_life_d = 1'b0;
            osc2_d       = 1'b0;
            extinct_d    = 1'b0;
            seq_err_d    = 1'b0;
        end else if (cell_if.in_valid) begin
            if (!idx_match) begin
                seq_err_d = 1'b1;
                run_cnt_d = '0;
                exp_d     = '0;
            end
            // An out-of-order index 0 restarts capture with this cell.
            if (idx_match || cell_if.in_idx == '0) begin
                cap_d[cell_if.in_idx] = cell_if.in_bit;
                run_cnt_d = (idx_match ? run_cnt_q : '0) + POP_W'(cell_if.in_bit);
                exp_d     = cell_if.in_idx + IDX_W'(1);
                if (idx_match && cell_if.in_idx == LAST_IDX) begin
                    cur_d         = new_frame;
                    prev1_d       = cur_q;
                    prev2_d       = prev1_q;
                    population_d  = new_pop;
                    run_cnt_d     = '0;
                    exp_d         = '0;
                    generation_d  = sat_inc(generation_q);
                    still_life_d  = have_prev_q & (new_frame == cur_q);
                    osc2_d        = have_prev2_q & (new_frame == prev1_q) & (new_frame != cur_q);
                    extinct_d     = (new_pop == '0);
                    have_prev2_d  = have_prev_q;
                    have_prev_d   = 1'b1;
                    frame_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q         <= '0;
            cur_q         <= '0;
            prev1_q       <= '0;
            prev2_q       <= '0;
            run_cnt_q     <= '0;
            exp_q         <= '0;
            have_prev_q   <= 1'b0;
            have_prev2_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            population_q  <= '0;
            generation_q  <= '0;
            still_life_q  <= 1'b0;
            osc2_q        <= 1'b0;
            extinct_q     <= 1'b0;
            seq_err_q     <= 1'b0;
            row_data_q    <= '0;
        end else begin
            cap_q         <= cap_d;
            cur_q         <= cur_d;
            prev1_q       <= prev1_d;
            prev2_q       <= prev2_d;
            run_cnt_q     <= run_cnt_d;
            exp_q         <= exp_d;
            have_prev_q   <= have_prev_d;
            have_prev2_q  <= have_prev2_d;
            frame_valid_q <= frame_valid_d;
            population_q  <= population_d;
            generation_q  <= generation_d;
            still_life_q  <= still_life_d;
            osc2_q        <= osc2_d;
            extinct_q     <= extinct_d;
            seq_err_q     <= seq_err_d;
            row_data_q    <= row_data_d;
        end
    end

    assign row_data    = row_data_q;
    assign frame_valid = frame_valid_q;
    assign population  = population_q;
    assign generation  = generation_q;
    assign still_life  = still_life_q;
    assign osc2        = osc2_q;
    assign extinct     = extinct_q;
    assign seq_err     = seq_err_q;
endmodule

// File: tb/tb_life_frame_capture.sv
// Directed bench for life_frame_capture: streams hand-built 8x8 frames and
// compares the derived outputs against hand-computed values.
module tb_life_frame_capture;
    localparam logic [63:0] BLINK_V = 64'h0000_0008_0808_0000; // cells 19,27,35
    localparam logic [63:0] BLINK_H = 64'h0000_0000_1C00_0000; // cells 26,27,28
    localparam logic [63:0] BLOCK   = 64'h0000_0018_1800_0000; // cells 27,28,35,36
    localparam logic [63:0] ZEROS   = 64'h0;
    localparam logic [63:0] ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic [2:0]  row_sel = 3'd0;
    logic [7:0]  row_data;
    logic        frame_valid;
    logic [6:0]  population;
    logic [15:0] generation;
    logic        still_life, osc2, extinct, seq_err;

    int checks = 0;
    int errors = 0;

    life_frame_capture_if #(.IDX_W(6)) cell_if ();

    life_frame_capture #(.ROWS(8), .COLS(8), .GEN_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .cell_if     (cell_if.slave),
        .row_sel     (row_sel),
        .row_data    (row_data),
        .frame_valid (frame_valid),
        .population  (population),
        .generation  (generation),
        .still_life  (still_life),
        .osc2        (osc2),
        .extinct     (extinct),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cell(input int idx, input logic b);
        cell_if.in_valid = 1'b1;
        cell_if.in_idx   = 6'(idx);
        cell_if.in_bit   = b;
        tick();
    endtask

    task automatic idle(input int n);
        cell_if.in_valid = 1'b0;
        repeat (n) tick();
    endtask

    // Streams cells 0..63; a 3-cycle gap is inserted before gap_a and gap_b.
    task automatic send_frame(input logic [63:0] f, input int gap_a, input int gap_b);
        for (int i = 0; i < 64; i++) begin
            if (i == gap_a || i == gap_b) idle(3);
            send_cell(i, f[i]);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_fv"},   frame_valid, 0);
        chk({tag, "_pop"},  population,  0);
        chk({tag, "_gen"},  generation,  0);
        chk({tag, "_sl"},   still_life,  0);
        chk({tag, "_osc"},  osc2,        0);
        chk({tag, "_ext"},  extinct,     0);
        chk({tag, "_serr"}, seq_err,     0);
        chk({tag, "_row"},  row_data,    0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        cell_if.in_valid = 1'b0;
        cell_if.in_idx   = '0;
        cell_if.in_bit   = 1'b0;
        tick();
        tick();
        check_zero("reset");
        rst_n = 1'b1;
        tick();

        // Vertical blinker, first frame after reset.
        send_frame(BLINK_V, -1, -1);
        chk("blink_fv",  frame_valid, 1);
        chk("blink_pop", population,  3);
        chk("blink_gen", generation,  1);
        chk("blink_sl",  still_life,  0);
        chk("blink_osc", osc2,        0);
        chk("blink_ext", extinct,     0);
        row_sel = 3'd3;
        idle(1);
        chk("blink_fv_pulse", frame_valid, 0);
        chk("blink_row3", row_data, 8'h08);
        row_sel = 3'd0;
        tick();
        chk("blink_row0", row_data, 8'h00);

        // Block twice back-to-back.
        do_reset();
        send_frame(BLOCK, -1, -1);
        chk("block1_fv", frame_valid, 1);
        chk("block1_sl", still_life,  0);
        send_frame(BLOCK, -1, -1);
        chk("block2_fv",  frame_valid, 1);
        chk("block2_sl",  still_life,  1);
        chk("block2_osc", osc2,        0);
        chk("block2_pop", population,  4);
        chk("block2_gen", generation,  2);

        // Blinker V / H / V, then extinction and a full grid.
        do_reset();
        send_frame(BLINK_V, -1, -1);
        send_frame(BLINK_H, -1, -1);
        chk("osc_f2_osc", osc2,       0);
        chk("osc_f2_sl",  still_life, 0);
        send_frame(BLINK_V, -1, -1);
        chk("osc_f3_fv",  frame_valid, 1);
        chk("osc_f3_osc", osc2,        1);
        chk("osc_f3_sl",  still_life,  0);
        chk("osc_f3_gen", generation,  3);
        send_frame(ZEROS, -1, -1);
        chk("zero_ext", extinct,    1);
        chk("zero_pop", population, 0);
        chk("zero_osc", osc2,       0);
        send_frame(ONES, -1, -1);
        chk("ones_pop", population, 64);
        chk("ones_ext", extinct,    0);
        chk("ones_gen", generation, 5);
        row_sel = 3'd7;
        idle(1);
        chk("ones_row7", row_data, 8'hFF);

        // Out-of-order index: partial frame dropped, error sticky.
        for (int i = 0; i <= 10; i++) send_cell(i, 1'b1);
        send_cell(40, 1'b1);
        chk("seq_fv", frame_valid, 0);
        chk("seq_err_set", seq_err, 1);
        idle(3);
        chk("seq_fv_idle", frame_valid, 0);
        chk("seq_gen_hold", generation, 5);
        chk("seq_pop_hold", population, 64);
        send_frame(BLINK_V, -1, -1);
        chk("seq_clean_fv",   frame_valid, 1);
        chk("seq_clean_pop",  population,  3);
        chk("seq_clean_gen",  generation,  6);
        chk("seq_clean_serr", seq_err,     1);
        row_sel = 3'd3;
        idle(1);

        // Soft clear, with a competing cell in the same cycle.
        clear = 1'b1;
        send_cell(0, 1'b1);
        clear = 1'b0;
        cell_if.in_valid = 1'b0;
        chk("clr_serr", seq_err,    0);
        chk("clr_gen",  generation, 0);
        chk("clr_pop",  population, 0);
        chk("clr_row_lag", row_data, 8'h08);
        tick();
        chk("clr_row", row_data, 8'h00);
        send_frame(ZEROS, -1, -1);
        chk("clr_f1_fv",   frame_valid, 1);
        chk("clr_f1_serr", seq_err,     0);
        chk("clr_f1_sl",   still_life,  0);
        chk("clr_f1_ext",  extinct,     1);
        chk("clr_f1_gen",  generation,  1);

        // Asynchronous reset mid-frame, then a frame with gaps.
        for (int i = 0; i < 30; i++) send_cell(i, BLINK_V[i]);
        cell_if.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        tick();
        rst_n = 1'b1;
        send_frame(BLINK_V, 20, 45);
        chk("gap_fv",  frame_valid, 1);
        chk("gap_gen", generation,  1);
        chk("gap_sl",  still_life,  0);
        chk("gap_pop", population,  3);
        chk("gap_serr", seq_err,    0);
        row_sel = 3'd4;
        idle(1);
        chk("gap_row4", row_data, 8'h08);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
